// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO plus launch sequencer that sits directly in front of a UART
//   transmitter. Producers push bytes at up to one per clock. The sequencer
//   pops one byte at a time and presents it to the UART enable/i_data/o_busy
//   handshake, preserving order. The byte is held stable for the whole frame,
//   and enable is never pulsed while the UART reports busy.
//
// Handshakes:
//   Push side : wr_en acts as valid and !full as ready. A byte is taken on a
//               rising edge where wr_en=1 and the registered full=0. A push
//               while full is dropped and reported by a one-cycle overflow.
//   UART side : uart_enable is a one-cycle launch pulse. uart_data is valid
//               from that cycle until uart_busy falls again. If busy never
//               rises within BUSY_TIMEOUT cycles of the pulse, timeout pulses
//               and the byte is treated as sent.
//
// Ports:
//   clk, reset    single clock, synchronous active-high reset
//   wr_en/wr_data push request and byte
//   full, count   FIFO status (count = entries queued)
//   overflow      1-cycle pulse: push rejected because the FIFO was full
//   uart_enable   1-cycle launch pulse to the UART
//   uart_data     byte to the UART, held for the whole frame
//   uart_busy     UART o_busy
//   timeout       1-cycle pulse: busy never rose after a launch
//   idle          sequencer idle and FIFO empty
//   o_dbg_state   current sequencer state, for debug and checkers
//
// BUSY_TIMEOUT must be >= 2. DEPTH must be a power of 2 and >= 2.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    uart_enable,
  output logic [DATA_WIDTH-1:0]   uart_data,
  input  logic                    uart_busy,
  output logic                    timeout,
  output logic                    idle,
  output logic [1:0]              o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // The timer starts at 0 in the first WAIT_BUSY cycle, which is already one
  // cycle after the enable pulse, and the timeout flag is registered. Firing
  // at BUSY_TIMEOUT-2 therefore makes timeout visible BUSY_TIMEOUT cycles
  // after uart_enable.
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 2);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_overflow;
  logic                  r_enable;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_timeout;
  logic                  r_idle;
  logic [1:0]            r_state;
  logic [TW-1:0]         r_timer;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_timer_done;
  logic [CW-1:0]         w_count_next;
  logic [1:0]            w_state_next;

  always_comb begin
    // Push uses the registered full, so a pop in the same cycle cannot make
    // room for a push that arrives while full.
    w_push       = wr_en && !r_full;
    w_pop        = (r_state == S_IDLE) && (r_count != '0) && !uart_busy;
    w_timer_done = (r_timer == TIMER_LAST);

    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end

    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_state_next = S_LAUNCH;
      S_LAUNCH:    w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_timer_done) begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!uart_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Storage is not reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_enable   <= 1'b0;
      r_data     <= '0;
      r_timeout  <= 1'b0;
      r_idle     <= 1'b1;
      r_state    <= S_IDLE;
      r_timer    <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of 2.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      r_count    <= w_count_next;
      r_full     <= (w_count_next == DEPTH_C);
      r_overflow <= wr_en && r_full;
      r_state    <= w_state_next;
      // The pop edge is also the edge that enters LAUNCH, so the registered
      // enable is high for exactly the LAUNCH cycle.
      r_enable   <= w_pop;
      r_timeout  <= (r_state == S_WAIT_BUSY) && !uart_busy && w_timer_done;
      r_idle     <= (w_state_next == S_IDLE) && (w_count_next == '0);
      if (r_state == S_LAUNCH) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT_BUSY) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign full        = r_full;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign uart_enable = r_enable;
  assign uart_data   = r_data;
  assign timeout     = r_timeout;
  assign idle        = r_idle;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo (DEPTH=4, BUSY_TIMEOUT=4). A small UART
//   stand-in drives uart_busy: tied low, held high, or a FRAME-cycle busy
//   window after each enable. Every launched byte is compared against an
//   expected queue filled by the push driver. A negedge monitor checks that
//   enable never coincides with busy and that uart_data stays put during a
//   frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DW           = 8;
  localparam int DEPTH        = 4;
  localparam int BUSY_TIMEOUT = 4;
  localparam int FRAME        = 6;
  localparam int ST_IDLE      = 0;
  localparam int ST_WAIT_DONE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic [2:0]    count;
  logic          overflow;
  logic          uart_enable;
  logic [DW-1:0] uart_data;
  logic          uart_busy;
  logic          timeout;
  logic          idle;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .uart_enable(uart_enable),
    .uart_data  (uart_data),
    .uart_busy  (uart_busy),
    .timeout    (timeout),
    .idle       (idle),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks  = 0;
  int            n_pass    = 0;
  int            n_enables = 0;
  int            acc_push  = 0;
  int            busy_mode = 2;  // 0: tied low, 1: held high, 2: frame model
  int            frame_cnt = 0;
  bit            mon_en    = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- UART stand-in ----------------
  always @(posedge clk) begin
    if (reset) begin
      uart_busy <= 1'b0;
      frame_cnt <= 0;
    end else begin
      if (uart_enable) begin
        n_enables <= n_enables + 1;
        if (exp_q.size() > 0) begin
          check("rx_order", 32'(uart_data), 32'(exp_q.pop_front()));
        end else begin
          n_checks++;
          $error("FAIL rx_spurious_enable: observed byte 0x%0h expected no enable", uart_data);
        end
      end
      case (busy_mode)
        0: uart_busy <= 1'b0;
        1: uart_busy <= 1'b1;
        default: begin
          if (uart_enable) begin
            uart_busy <= 1'b1;
            frame_cnt <= FRAME - 1;
          end else if (uart_busy) begin
            if (frame_cnt == 0) uart_busy <= 1'b0;
            else frame_cnt <= frame_cnt - 1;
          end
        end
      endcase
    end
  end

  // ---------------- protocol monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("no_enable_while_busy", 32'(uart_enable && uart_busy), 32'd0);
      if (prev_hold && (uart_enable || uart_busy)) begin
        check("data_stable", 32'(uart_data), 32'(prev_data));
      end
    end
    prev_hold <= uart_enable || uart_busy;
    prev_data <= uart_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    acc_push++;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while (!(n_enables == acc_push && idle === 1'b1 && uart_busy === 1'b0) && cyc < 400) begin
      tick();
      cyc++;
    end
    check({tag, "_drained_in_time"}, 32'(cyc < 400), 32'd1);
    check({tag, "_enable_count"}, 32'(n_enables), 32'(acc_push));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic random_push(input int n, input int max_gap, input string tag);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      repeat ($urandom_range(0, max_gap)) tick();
      // Outstanding bytes bound the FIFO occupancy, so keeping them below
      // DEPTH guarantees the push is accepted.
      while ((acc_push - n_enables) >= DEPTH && guard < 200) begin
        tick();
        guard++;
      end
      push(8'($urandom_range(0, 255)));
      check({tag, "_no_overflow"}, 32'(overflow), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    tick();
    tick();
    check("rst_full",     32'(full),        32'd0);
    check("rst_count",    32'(count),       32'd0);
    check("rst_overflow", 32'(overflow),    32'd0);
    check("rst_enable",   32'(uart_enable), 32'd0);
    check("rst_data",     32'(uart_data),   32'd0);
    check("rst_timeout",  32'(timeout),     32'd0);
    check("rst_idle",     32'(idle),        32'd1);
    check("rst_state",    32'(dbg_state),   32'(ST_IDLE));
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1: single byte, launch two cycles after the push
    push(8'h55);
    check("t1_count_t1",  32'(count),       32'd1);
    check("t1_enable_t1", 32'(uart_enable), 32'd0);
    tick();
    check("t1_enable_t2", 32'(uart_enable), 32'd1);
    check("t1_data_t2",   32'(uart_data),   32'h55);
    tick();
    check("t1_enable_t3", 32'(uart_enable), 32'd0);
    wait_drain("t1");

    // 2: fill while busy, overflow, then drain in order
    busy_mode = 1;
    tick();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    check("t2_full",  32'(full),  32'd1);
    check("t2_count", 32'(count), 32'd4);
    check("t2_idle",  32'(idle),  32'd0);
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    tick();
    wr_en   = 1'b0;
    check("t2_overflow_pulse", 32'(overflow), 32'd1);
    check("t2_count_after_drop", 32'(count), 32'd4);
    tick();
    check("t2_overflow_clear", 32'(overflow), 32'd0);
    check("t2_no_launch_while_busy", 32'(n_enables), 32'd1);
    busy_mode = 2;
    wait_drain("t2");

    // 3: busy never rises -> timeout BUSY_TIMEOUT cycles after each enable
    busy_mode = 0;
    tick();
    push(8'h11);
    push(8'h22);
    check("t3_enable_first", 32'(uart_enable), 32'd1);
    check("t3_data_first",   32'(uart_data),   32'h11);
    check("t3_count_first",  32'(count),       32'd1);
    repeat (3) tick();
    check("t3_timeout_early1", 32'(timeout), 32'd0);
    tick();
    check("t3_timeout_first", 32'(timeout), 32'd1);
    tick();
    check("t3_enable_second",  32'(uart_enable), 32'd1);
    check("t3_data_second",    32'(uart_data),   32'h22);
    check("t3_timeout_cleared", 32'(timeout),    32'd0);
    repeat (3) tick();
    check("t3_timeout_early2", 32'(timeout), 32'd0);
    tick();
    check("t3_timeout_second", 32'(timeout), 32'd1);
    check("t3_idle_end",       32'(idle),    32'd1);
    busy_mode = 2;
    wait_drain("t3");

    // 4: push and pop on the same edge keep count at 1
    busy_mode = 1;
    tick();
    push(8'h3C);
    busy_mode = 2;
    tick();
    push(8'hC3);
    check("t4_count_same_cycle", 32'(count),       32'd1);
    check("t4_full_same_cycle",  32'(full),        32'd0);
    check("t4_enable",           32'(uart_enable), 32'd1);
    check("t4_data",             32'(uart_data),   32'h3C);
    repeat (3) tick();
    check("t4_count_in_frame", 32'(count), 32'd1);
    wait_drain("t4");

    // wrap-around: 3*DEPTH bytes with random stalls, then a denser burst
    random_push(3 * DEPTH, 3, "wrap");
    wait_drain("wrap");
    random_push(20, 1, "rand");
    wait_drain("rand");

    // 5: reset in WAIT_DONE with three bytes queued
    push(8'hA5);
    push(8'h5A);
    push(8'hC0);
    push(8'h0C);
    check("t5_state_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    check("t5_count_queued",    32'(count),     32'd3);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("t5_rst_count",  32'(count),       32'd0);
    check("t5_rst_enable", 32'(uart_enable), 32'd0);
    check("t5_rst_idle",   32'(idle),        32'd1);
    check("t5_rst_full",   32'(full),        32'd0);
    check("t5_rst_data",   32'(uart_data),   32'd0);
    check("t5_rst_state",  32'(dbg_state),   32'(ST_IDLE));
    reset = 1'b0;
    repeat (40) tick();
    check("t5_no_stale_enables", 32'(n_enables), 32'(acc_push - 3));
    check("t5_idle_after",       32'(idle),      32'd1);
    check("t5_count_after",      32'(count),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed run still active expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
